// File: rtl/ls7402.sv
// ls7402 - quad 2-input NOR (74LS02 style) glue primitive.
//
// y is a purely combinational NOR and never depends on clk/rst.
// y_q is a registered copy of y, reset to 4'b1111 (NOR of idle-low inputs).
//
// Optional debug feature, enabled by defining the macro LS7402_ACTIVITY_EN:
//   per-gate rising-edge activity counters (saturating), synchronous clear,
//   counter readback mux and an any_rise flag. With the macro undefined the
//   counter logic is not built, cnt_out and any_rise are tied low, and clr /
//   cnt_sel are ignored; the port list is identical in both builds.
//
// CNT_W must be at least 2.
`timescale 1ns/1ps

module ls7402 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [3:0]       y,
    output logic [3:0]       y_q,
    input  logic             clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic             any_rise
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Bitwise NOR of the four gate input pairs.
    function automatic logic [3:0] nor4(input logic [3:0] x, input logic [3:0] z);
        return ~(x | z);
    endfunction

    logic [3:0] y_d;

    // NOR path: no clock or reset involvement at all.
    always_comb begin
        y_d = nor4(a, b);
        y   = y_d;
    end

    // Output register: registered copy of y, idles at all-ones under reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 4'b1111;
        end else begin
            y_q <= y_d;
        end
    end

`ifdef LS7402_ACTIVITY_EN

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [3:0]       rise_s;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Per-gate rise: output currently high while its registered copy is low.
    always_comb begin
        rise_s   = y_d & ~y_q;
        any_rise = |rise_s;
    end

    // Counter next state: clear wins over a simultaneous increment.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (clr) begin
                cnt_d[i] = CNT_ZERO;
            end else if (rise_s[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Readback mux selecting one gate's counter.
    always_comb begin
        case (cnt_sel)
            2'd0:    cnt_out = cnt_q[0];
            2'd1:    cnt_out = cnt_q[1];
            2'd2:    cnt_out = cnt_q[2];
            2'd3:    cnt_out = cnt_q[3];
            default: cnt_out = CNT_ZERO;
        endcase
    end

`else

    logic unused_s;

    // Debug controls are accepted but have no effect in this build.
    always_comb begin
        unused_s = clr ^ (^cnt_sel);
    end

    // Debug outputs tied low when activity counting is not built.
    always_comb begin
        cnt_out  = CNT_ZERO;
        any_rise = 1'b0;
    end

`endif

endmodule

// File: tb/tb_ls7402.sv
// Self-checking bench for ls7402: directed scenarios plus randomized traffic
// compared against a behavioural model (per-bit NOR, integer counters).
`timescale 1ns/1ps

module tb_ls7402;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LS7402_ACTIVITY_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             clk_run;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       y;
    logic [3:0]       y_q;
    logic             clr;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;
    logic             any_rise;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         cnt_m [4];
    logic [3:0] yq_m;

    ls7402 #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .y       (y),
        .y_q     (y_q),
        .clr     (clr),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out),
        .any_rise(any_rise)
    );

    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
    end
    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_nor(input logic [3:0] x, input logic [3:0] z);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = !(x[i] || z[i]);
        return r;
    endfunction

    function automatic logic [31:0] exp_cnt(input logic [1:0] sel);
        return EN ? 32'(cnt_m[sel]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_rise();
        logic [3:0] yn;
        int         n;
        yn = ref_nor(a, b);
        n  = 0;
        for (int i = 0; i < 4; i++) if (yn[i] && !yq_m[i]) n++;
        return (EN && n > 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        yq_m = 4'hF;
    endtask

    // Apply what happens at one rising clock edge to the model.
    task automatic model_edge();
        logic [3:0] yn;
        yn = ref_nor(a, b);
        for (int i = 0; i < 4; i++) begin
            if (clr) cnt_m[i] = 0;
            else if (yn[i] && !yq_m[i] && cnt_m[i] < CNT_MAX) cnt_m[i] = cnt_m[i] + 1;
        end
        yq_m = yn;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registers.
    task automatic step(input logic [3:0] na, input logic [3:0] nb, input logic nclr);
        a       = na;
        b       = nb;
        clr     = nclr;
        cnt_sel = 2'($urandom_range(0, 3));
        #1;
        chk("y", 32'(y), 32'(ref_nor(a, b)));
        chk("any_rise", 32'(any_rise), exp_rise());
        @(posedge clk);
        model_edge();
        #1;
        chk("y_q", 32'(y_q), 32'(yq_m));
        chk("cnt_out", 32'(cnt_out), exp_cnt(cnt_sel));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_y_q", 32'(y_q), 32'h0000000F);
        chk("rst_cnt", 32'(cnt_out), 32'd0);
        chk("rst_y", 32'(y), 32'(ref_nor(a, b)));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr     = 1'b0;
        cnt_sel = 2'd0;

        // Combinational truth, no clock, rst never driven
        a = 4'b0000; b = 4'b0011; #10;
        chk("truth0", 32'(y), 32'h0000000C);
        a = 4'b1010; b = 4'b0110; #10;
        chk("truth1", 32'(y), 32'h00000001);

        // Exhaustive NOR sweep
        for (int k = 0; k < 256; k++) begin
            a = 4'(k >> 4);
            b = 4'(k);
            #1;
            chk("sweep", 32'(y), 32'(ref_nor(a, b)));
        end

        // Register/reset with a = 1111
        a = 4'b1111; b = 4'b0000;
        rst = 1'b1;
        clk_run = 1'b1;
        #1;
        chk("rst_hold0", 32'(y_q), 32'h0000000F);
        @(posedge clk); #1;
        chk("rst_hold1", 32'(y_q), 32'h0000000F);
        chk("rst_cnt0", 32'(cnt_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_edge();
        #1;
        chk("first_edge", 32'(y_q), 32'h00000000);

        // Counting: toggle a[2], two cycles per value, three times
        for (int r = 0; r < 3; r++) begin
            step(4'b1011, 4'b0000, 1'b0);
            step(4'b1011, 4'b0000, 1'b0);
            step(4'b1111, 4'b0000, 1'b0);
            step(4'b1111, 4'b0000, 1'b0);
        end
        cnt_sel = 2'd2; #1;
        chk("count_g2", 32'(cnt_out), EN ? 32'd3 : 32'd0);
        cnt_sel = 2'd0; #1;
        chk("count_g0", 32'(cnt_out), 32'd0);

        // Saturation: 300 rises on gate 1
        for (int r = 0; r < 300; r++) begin
            step(4'b1101, 4'b0000, 1'b0);
            step(4'b1111, 4'b0000, 1'b0);
        end
        cnt_sel = 2'd1; #1;
        chk("sat_g1", 32'(cnt_out), EN ? 32'd255 : 32'd0);

        // Clear coinciding with a rise on gate 1
        step(4'b1101, 4'b0000, 1'b1);
        cnt_sel = 2'd1; #1;
        chk("clr_prio", 32'(cnt_out), 32'd0);
        step(4'b1111, 4'b0000, 1'b0);

        // Randomized traffic with occasional clear and mid-run reset
        for (int r = 0; r < 400; r++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
            if (r % 97 == 50) pulse_rst();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ls7402.md
# ls7402

Quad 2-input NOR block modelled on the 74LS02, used as a glue-logic primitive in the CPU datapath and control decode. Four independent gates drive a purely combinational output `y`. The block also provides a registered copy of the output and per-gate rising-edge activity counters for on-chip debug. The NOR path never depends on clock or reset.

## Interface

- Clocking/reset: one clock; reset is asynchronous and active-high.

Parameters:
- `CNT_W`, default 8: width of each per-gate activity counter.

Ports:
- `clk` input 1: sole clock; rising-edge active.
- `rst` input 1: asynchronous, active-high reset of all registered state.
- `a` input 4: gate A inputs; bit i feeds gate i.
- `b` input 4: gate B inputs; bit i feeds gate i.
- `y` output 4: combinational NOR result, `y[i] = ~(a[i] | b[i])`.
- `y_q` output 4: `y` registered on `clk`.
- `clr` input 1: synchronous clear of all activity counters.
- `cnt_sel` input 2: selects which gate's counter is shown on `cnt_out`.
- `cnt_out` output CNT_W: activity counter of gate `cnt_sel`; combinational mux.
- `any_rise` output 1: combinational; high when any bit has `y[i]=1` and `y_q[i]=0`.

## Operation

- NOR path:
  - `y = ~(a | b)` bitwise, 4 bits, no state.
  - `y` is independent of `clk`, `rst`, `clr` and `cnt_sel`. It must be correct even if `clk`/`rst` are undriven (X/Z) or reset is never applied.
- Output register:
  - `y_q <= y` on every rising `clk`.
  - Reset value is 4'b1111, the NOR of idle-low inputs.
- Activity counters (one per gate, CNT_W bits):
  - Gate i's rise condition is `y[i]=1 && y_q[i]=0` at a rising `clk`.
  - On that condition, counter i increments by 1.
  - Counters saturate at all-ones (255 for CNT_W=8) and never wrap.
  - `clr=1` at a rising `clk` zeroes all four counters. It has priority over a simultaneous increment.
  - Reset value of all counters is 0.
- Readback:
  - `cnt_out` is counter[`cnt_sel`].
  - With the macro disabled, `cnt_out` is 0.
- Reset mid-operation:
  - Asserting `rst` immediately forces `y_q`=4'b1111 and counters=0.
  - `y` keeps tracking `a`/`b` throughout.

## Timing

- `y`: zero cycles, combinational. Must settle within 10 ns of an input change in simulation, with no registered stage.
- `y_q`: 1-cycle latency from `y`.
- Counter increment: visible on `cnt_out` one cycle after the edge where the rise condition holds.
- `clr`: takes effect at the next rising `clk`; `cnt_out` reads 0 from then on.
- `any_rise`: combinational from `a`, `b` and `y_q`.
- Reset release: first counted edge is the first rising `clk` after `rst` deasserts.

## Configuration

- Macro `LS7402_ACTIVITY_EN`.
- Defined:
  - Counters, `clr`, `cnt_sel`, `cnt_out` and `any_rise` are implemented as described.
- Undefined:
  - Counter logic is not built.
  - `cnt_out` is tied to 0 and `any_rise` is tied to 0.
  - `clr` and `cnt_sel` are ignored.
  - Ports remain present so instantiations are unchanged.
- `y` and `y_q` behave identically in both builds.

## Test plan

- Combinational truth, with no clock toggling and `rst` undriven:
  - a=4'b0000, b=4'b0011, wait 10 ns -> y=4'b1100.
  - a=4'b1010, b=4'b0110, wait 10 ns -> y=4'b0001.
- Exhaustive NOR: sweep all 256 {a,b} combinations -> y equals ~(a|b) every time.
- Register/reset:
  - Pulse `rst` with a=4'b1111 -> `y_q`=4'b1111 while `rst` is high.
  - After one `clk` edge with `rst` low -> `y_q`=4'b0000.
- Counting (macro defined):
  - Toggle a[2] between 1 and 0, each value held for 2 cycles, 3 times, with b=0.
  - cnt_sel=2 -> cnt_out=3.
  - cnt_sel=0 -> cnt_out=0.
- Saturation and clear (macro defined):
  - Force 300 rises on gate 1 -> cnt_out=255 with cnt_sel=1.
  - Assert clr together with a rise -> cnt_out=0 next cycle.
- Macro undefined: repeat the counting scenario -> cnt_out=0 and any_rise=0 throughout; `y`/`y_q` unchanged.
